// File: rtl/trigger_conditioner.sv
// Purpose: synchronise and debounce an asynchronous trigger into a clean level,
//          with rise/fall pulses, a qualification busy flag and a saturating glitch counter.
// Ports:   clk/reset (sync, active-high), raw_in (async), enable, hold (debounce length),
//          trig_out, rise_pulse, fall_pulse, busy, glitch_cnt.
module trigger_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8,
  parameter int GLITCH_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                enable,
  input  logic [HOLD_W-1:0]   hold,
  output logic                trig_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [HOLD_W-1:0]   CNT_ONE = HOLD_W'(1);
  localparam logic [GLITCH_W-1:0] GL_ONE  = GLITCH_W'(1);
  localparam logic [GLITCH_W-1:0] GL_MAX  = {GLITCH_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     cnt, cnt_nxt;
  logic [HOLD_W-1:0]     hold_q, hold_q_nxt;
  logic [GLITCH_W-1:0]   glitch_nxt, glitch_sat;
  logic                  trig_nxt, rise_nxt, fall_nxt, busy_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  // Rejected candidates stop counting once the counter is full.
  assign glitch_sat = (glitch_cnt == GL_MAX) ? glitch_cnt : glitch_cnt + GL_ONE;

  // State register: every registered output is loaded together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      state      <= ST_LOW;
      cnt        <= '0;
      hold_q     <= '0;
      glitch_cnt <= '0;
      trig_out   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], raw_in};
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hold_q     <= hold_q_nxt;
      glitch_cnt <= glitch_nxt;
      trig_out   <= trig_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic. cnt counts samples already seen at the candidate level,
  // so commit happens on the (hold_q+1)-th consecutive sample.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hold_q_nxt = hold_q;
    glitch_nxt = glitch_cnt;
    if (!enable) begin
      // Freeze: drop any candidate silently and park in the stable state
      // that matches the current output level.
      state_nxt = trig_out ? ST_HIGH : ST_LOW;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_LOW: begin
          if (s) begin
            hold_q_nxt = hold;
            if (hold == '0) begin
              state_nxt = ST_HIGH;
            end else begin
              cnt_nxt   = CNT_ONE;
              state_nxt = CHK_HIGH;
            end
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            state_nxt  = ST_LOW;
            cnt_nxt    = '0;
            glitch_nxt = glitch_sat;
          end else if (cnt == hold_q) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            hold_q_nxt = hold;
            if (hold == '0) begin
              state_nxt = ST_LOW;
            end else begin
              cnt_nxt   = CNT_ONE;
              state_nxt = CHK_LOW;
            end
          end
        end
        CHK_LOW: begin
          if (s) begin
            state_nxt  = ST_HIGH;
            cnt_nxt    = '0;
            glitch_nxt = glitch_sat;
          end else if (cnt == hold_q) begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: the clean level is implied by the next state (a CHK state
  // still shows the old level); pulses fire only when that level changes.
  always_comb begin
    trig_nxt = (state_nxt == ST_HIGH) || (state_nxt == CHK_LOW);
    busy_nxt = (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
    rise_nxt = trig_nxt & ~trig_out;
    fall_nxt = ~trig_nxt & trig_out;
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
module tb_trigger_conditioner;

  logic       clk;
  logic       reset;
  logic       raw_in;
  logic       enable;
  logic [7:0] hold;
  logic       trig_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  // Edge counters for the end-to-end sequence (trig_out feeds a timer trigger).
  bit mon = 1'b0;
  int n_rise = 0;
  int n_fall = 0;
  int n_trig_edges = 0;
  logic trig_prev = 1'b0;

  trigger_conditioner #(
    .SYNC_STAGES(2),
    .HOLD_W     (8),
    .GLITCH_W   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .enable    (enable),
    .hold      (hold),
    .trig_out  (trig_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       raw;
    logic       en;
    logic [7:0] hld;
    logic       e_trig;
    logic       e_rise;
    logic       e_fall;
    logic       e_busy;
    logic [7:0] e_gl;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_trig, input logic e_rise,
                         input logic e_fall, input logic e_busy, input logic [7:0] e_gl);
    check({tag, ".trig_out"},   32'(trig_out),   32'(e_trig));
    check({tag, ".rise_pulse"}, 32'(rise_pulse), 32'(e_rise));
    check({tag, ".fall_pulse"}, 32'(fall_pulse), 32'(e_fall));
    check({tag, ".busy"},       32'(busy),       32'(e_busy));
    check({tag, ".glitch_cnt"}, 32'(glitch_cnt), 32'(e_gl));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    check("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
    if (mon) begin
      if (rise_pulse) n_rise++;
      if (fall_pulse) n_fall++;
      if (trig_out && !trig_prev) n_trig_edges++;
      trig_prev = trig_out;
    end
  endtask

  task automatic glitch_once();
    raw_in = 1'b1; tick(); tick();
    raw_in = 1'b0; tick(); tick(); tick(); tick();
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 1'b1;
    enable = 1'b1;
    hold   = 8'd3;

    //            rst  raw  en   hold  trig rise fall busy glitch
    // Reset held with raw_in high.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    // Release: first sampling edge E0, commit on E0+5.
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    // Clean fall with hold=3.
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    // Two-cycle high glitch: busy for 2 cycles, then rejected.
    tbl[17] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[22] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    for (int i = 0; i < 23; i++) begin
      reset  = tbl[i].rst;
      raw_in = tbl[i].raw;
      enable = tbl[i].en;
      hold   = tbl[i].hld;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_trig, tbl[i].e_rise,
              tbl[i].e_fall, tbl[i].e_busy, tbl[i].e_gl);
    end

    // Saturation: 299 more glitches for 300 in total.
    for (int i = 2; i <= 300; i++) begin
      glitch_once();
      check($sformatf("glitch_sat%0d", i), 32'(glitch_cnt), (i > 255) ? 32'd255 : 32'(i));
      check($sformatf("glitch_sat%0d.trig_out", i), 32'(trig_out), 32'd0);
    end

    // Zero hold: level follows s with 2-cycle latency, never busy.
    hold = 8'd0;
    for (int t = 0; t < 16; t++) begin
      raw_in = (t >= 4 && t < 8);
      tick();
      chk_all($sformatf("zero_hold%0d", t), (t >= 6 && t < 10), (t == 6), (t == 10),
              1'b0, 8'd255);
    end

    // Hold change during qualification: hold_q=5 governs the rise,
    // the new hold=1 governs the following fall.
    hold = 8'd5;
    for (int t = 0; t < 16; t++) begin
      raw_in = (t < 10);
      if (t == 3) hold = 8'd1;
      tick();
      chk_all($sformatf("hold_chg%0d", t), (t >= 7 && t < 13), (t == 7), (t == 13),
              ((t >= 2 && t <= 6) || t == 12), 8'd255);
    end

    // Enable freeze at cnt=2, then restart from the stable state.
    hold = 8'd3;
    for (int t = 0; t < 14; t++) begin
      raw_in = 1'b1;
      enable = !(t >= 4 && t < 8);
      tick();
      chk_all($sformatf("freeze%0d", t), (t >= 11), (t == 11), 1'b0,
              (t == 2 || t == 3 || t == 8 || t == 9 || t == 10), 8'd255);
    end
    enable = 1'b1;
    raw_in = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    check("freeze_return_low", 32'(trig_out), 32'd0);

    // End-to-end: bounce faster than the clock, then a long clean level.
    hold = 8'd4;
    mon = 1'b1;
    trig_prev = trig_out;
    for (int b = 0; b < 4; b++) begin
      raw_in = 1'b1; #3;
      raw_in = 1'b0; #2;
    end
    raw_in = 1'b1;
    for (int t = 0; t < 24; t++) tick();
    check("e2e_level_high", 32'(trig_out), 32'd1);
    raw_in = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    mon = 1'b0;
    check("e2e_trig_rising_edges", 32'(n_trig_edges), 32'd1);
    check("e2e_rise_pulses", 32'(n_rise), 32'd1);
    check("e2e_fall_pulses", 32'(n_fall), 32'd1);
    check("e2e_level_low", 32'(trig_out), 32'd0);

    // Reset in the middle of qualification discards the candidate.
    hold = 8'd3;
    raw_in = 1'b1;
    tick(); tick(); tick();
    check("midq_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk_all("midq_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    raw_in = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    chk_all("midq_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
